y_frame_deser: RTL and testbench

Downstream consumer of the serial `y` bit produced by `circuit2`. Samples `y` on every rising clock edge, hunts for a fixed sync pattern, then shifts in one data word, an optional parity bit and one stop bit. Presents each frame as a registered parallel word with a one-cycle valid strobe, a per-frame error strobe, and a count of good frames.

---
 rtl/y_frame_deser.sv | 112 +++++++++++
 tb/tb_y_frame_deser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_frame_deser.sv
// rtl/y_frame_deser.sv - serial frame deserializer: sync hunt, data word, optional parity, stop bit
// Define Y_DESER_PARITY_EN to add an even-parity bit between data and stop.
module y_frame_deser #(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1011
) (
  input  logic              clk,
  input  logic              res,
  input  logic              din,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int               CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
`ifdef Y_DESER_PARITY_EN
    S_PAR  = 2'd2,
`endif
    S_STOP = 2'd3
  } state_t;

  state_t            state;
  logic [SYNC_W-1:0] hunt;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SYNC_W-1:0] hunt_next;
  logic              frame_ok;

  // The match is checked on the value after this edge's shift, so sync completes at its last bit.
  assign hunt_next = {hunt[SYNC_W-2:0], din};

`ifdef Y_DESER_PARITY_EN
  logic par_err;
  assign frame_ok = din && !par_err;
`else
  assign frame_ok = din;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= S_HUNT;
      hunt      <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 8'd0;
`ifdef Y_DESER_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_HUNT: begin
          hunt <= hunt_next;
          if (hunt_next == SYNC) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        S_DATA: begin
          sreg    <= {sreg[DATA_W-2:0], din};
          bit_cnt <= bit_cnt + ONE;
          if (bit_cnt == LAST) begin
`ifdef Y_DESER_PARITY_EN
            state <= S_PAR;
`else
            state <= S_STOP;
`endif
          end
        end
`ifdef Y_DESER_PARITY_EN
        S_PAR: begin
          par_err <= din ^ (^sreg);
          state   <= S_STOP;
        end
`endif
        S_STOP: begin
          if (frame_ok) begin
            data      <= sreg;
            valid     <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            frame_err <= 1'b1;
          end
          // Clearing the hunt register keeps the stop bit out of the next sync search.
          hunt  <= '0;
          busy  <= 1'b0;
          state <= S_HUNT;
`ifdef Y_DESER_PARITY_EN
          par_err <= 1'b0;
`endif
        end
        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_y_frame_deser.sv
// tb/tb_y_frame_deser.sv - scoreboard bench for y_frame_deser (default parameters)
// Follows Y_DESER_PARITY_EN to match the frame format of the design build.
module tb_y_frame_deser;

`ifdef Y_DESER_PARITY_EN
  localparam int FRAME_LEN = 4 + 8 + 2;
`else
  localparam int FRAME_LEN = 4 + 8 + 1;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       din = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] frame_cnt;

  typedef struct {
    logic       err;
    logic [7:0] d;
    logic [7:0] c;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         vcount = 0;
  int         last_valid_cyc = -1;
  bit         gap_chk = 1'b0;
  logic [7:0] model_data = 8'd0;
  logic [7:0] model_cnt = 8'd0;

  y_frame_deser dut (
    .clk       (clk),
    .res       (res),
    .din       (din),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Drive one bit, let the DUT sample it, then check any strobe against the scoreboard.
  task automatic tick(input logic b);
    exp_t e;
    din = b;
    @(posedge clk);
    #1;
    cyc++;
    total++;
    if (valid && frame_err) begin
      bad++;
      $display("FAIL strobe_excl: valid=%0b frame_err=%0b required not both", valid, frame_err);
    end
    if (valid || frame_err) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b at cycle %0d, required none", valid, frame_err, cyc);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.err) begin
          bad++;
          $display("FAIL strobe_kind: frame_err=%0b required %0b", frame_err, e.err);
        end
        total++;
        if (data !== e.d) begin
          bad++;
          $display("FAIL data: got %h required %h", data, e.d);
        end
        total++;
        if (frame_cnt !== e.c) begin
          bad++;
          $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, e.c);
        end
      end
      if (valid) begin
        vcount++;
        if (gap_chk && last_valid_cyc >= 0) begin
          total++;
          if (cyc - last_valid_cyc !== FRAME_LEN) begin
            bad++;
            $display("FAIL valid_gap: got %0d required %0d", cyc - last_valid_cyc, FRAME_LEN);
          end
        end
        last_valid_cyc = cyc;
      end
    end
  endtask

  task automatic check_busy(input logic exp_b, input string tag);
    total++;
    if (busy !== exp_b) begin
      bad++;
      $display("FAIL busy_%s: got %0b required %0b", tag, busy, exp_b);
    end
  endtask

  // Full frame from HUNT: 1011, word MSB first, optional parity (flipped on request), stop.
  task automatic send_frame(input logic [7:0] w, input logic stop_b, input logic par_flip);
    logic [3:0] sp;
    logic       good;
    exp_t       e;
    sp = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      tick(sp[3-i]);
      check_busy(i == 3, "sync");
    end
    for (int i = 0; i < 8; i++) begin
      tick(w[7-i]);
      check_busy(1'b1, "data");
    end
`ifdef Y_DESER_PARITY_EN
    tick((^w) ^ par_flip);
    check_busy(1'b1, "par");
    good = stop_b && !par_flip;
`else
    good = stop_b;
`endif
    if (good) begin
      model_data = w;
      model_cnt  = model_cnt + 8'd1;
    end
    e.err = !good;
    e.d   = model_data;
    e.c   = model_cnt;
    exp_q.push_back(e);
    tick(stop_b);
    check_busy(1'b0, "stop");
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_strobe: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    #2;
    res = 1'b1;
    exp_q.delete();
    model_data = 8'd0;
    model_cnt  = 8'd0;
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if ({data, valid, frame_err, busy, frame_cnt} !== 19'd0) begin
      bad++;
      $display("FAIL %s: data=%h valid=%0b err=%0b busy=%0b cnt=%0d required all 0",
               tag, data, valid, frame_err, busy, frame_cnt);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    res = 1'b0;
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(1'b0);
    total++;
    if (frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL good_cnt: got %0d required 1", frame_cnt);
    end
  endtask

  task automatic test_parity();
`ifdef Y_DESER_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1);
`else
    send_frame(8'h5A, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_bad_stop();
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(1'b0);
    check_busy(1'b0, "after_bad_stop");
  endtask

  task automatic test_noise_overlap();
    logic [5:0] noise;
    noise = 6'b011010;
    for (int i = 0; i < 6; i++) begin
      tick(noise[5-i]);
      check_busy(1'b0, "noise");
    end
    send_frame(8'hF0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] sp;
    sp = 4'b1011;
    for (int i = 0; i < 4; i++) tick(sp[3-i]);
    for (int i = 0; i < 5; i++) tick(1'b1);
    #2;
    res = 1'b1;
    #1;
    check_zero_outputs("reset_async");
    exp_q.delete();
    model_data = 8'd0;
    model_cnt  = 8'd0;
    @(posedge clk);
    #1;
    res = 1'b0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    check_busy(1'b0, "after_reset");
    repeat (4) tick(1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    do_reset();
    vcount         = 0;
    last_valid_cyc = -1;
    gap_chk        = 1'b1;
    for (int n = 0; n < 256; n++) begin
      w = 8'($urandom_range(0, 255));
      send_frame(w, 1'b1, 1'b0);
    end
    gap_chk = 1'b0;
    total++;
    if (frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL wrap_cnt: got %0d required 0", frame_cnt);
    end
    total++;
    if (vcount !== 256) begin
      bad++;
      $display("FAIL wrap_valids: got %0d required 256", vcount);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_bad_stop();
    test_noise_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
